// File: rtl/rra.sv
// rtl/rra.sv - N-way round-robin arbiter with registered one-hot grant
// Rotate the request vector to the pointer, priority-encode, then unrotate the winner.
module rra #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] GNT
);

    localparam int PW = $clog2(N);
    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] off;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_next;
    logic [PW:0]   sum;
    logic [N-1:0]  rot;
    logic          found;

    always_comb begin
        rot   = N'({REQ, REQ} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = j[PW-1:0];
            end
        end
        sum      = {1'b0, ptr} + {1'b0, off};
        win      = (sum >= N_W) ? PW'(sum - N_W) : sum[PW-1:0];
        ptr_next = (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            GNT <= '0;
            ptr <= '0;
        end else if (found) begin
            GNT <= N'(1) << win;
            ptr <= ptr_next;
        end else begin
            GNT <= '0;
        end
    end

endmodule

// File: tb/tb_rra.sv
// tb/tb_rra.sv - self-checking bench for rra: directed tables, corner sequences, random scoreboard
module tb_rra;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] GNT;

    int checks = 0;
    int failures = 0;

    rra #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .REQ(REQ), .GNT(GNT));

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
    } vec_t;

    logic [N-1:0] exp_q[$];
    int           mptr = 0;
    int           waits[N];

    function automatic logic [N-1:0] model_step(input logic rst, input logic [N-1:0] req);
        logic [N-1:0] g;
        int           idx;
        g = '0;
        if (!rst) begin
            mptr = 0;
            return g;
        end
        for (int i = 0; i < N; i++) begin
            idx = (mptr + i) % N;
            if (req[idx]) begin
                g[idx] = 1'b1;
                mptr = (idx + 1) % N;
                return g;
            end
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; expectation comes from the table when use_exp is set, otherwise from the model.
    task automatic cycle(input string name, input logic rst, input logic [N-1:0] req,
                         input logic use_exp, input logic [N-1:0] exp_gnt);
        logic [N-1:0] m;
        logic [N-1:0] g;
        logic         any_grant;
        rst_n = rst;
        REQ   = req;
        m = model_step(rst, req);
        exp_q.push_back(use_exp ? exp_gnt : m);
        @(posedge clk);
        #1;
        check(name, 32'(GNT), 32'(exp_q.pop_front()));
        g = GNT;
        check({name, "_onehot"}, 32'($onehot0(g)), 32'd1);
        check({name, "_subset"}, 32'(g & ~(rst ? req : '0)), 32'd0);
        any_grant = |g;
        for (int i = 0; i < N; i++) begin
            if (!rst || !req[i] || g[i]) waits[i] = 0;
            else if (any_grant) waits[i]++;
            check($sformatf("%s_wait%0d", name, i), 32'(waits[i] <= N - 1), 32'd1);
        end
    endtask

    vec_t seq_tbl[10];
    vec_t fair_tbl[10];

    initial begin
        for (int i = 0; i < N; i++) waits[i] = 0;

        seq_tbl[0] = '{1'b0, 4'b1111, 4'b0000};
        seq_tbl[1] = '{1'b0, 4'b1111, 4'b0000};
        seq_tbl[2] = '{1'b1, 4'b1000, 4'b1000};
        seq_tbl[3] = '{1'b1, 4'b1010, 4'b0010};
        seq_tbl[4] = '{1'b1, 4'b0010, 4'b0010};
        seq_tbl[5] = '{1'b1, 4'b0110, 4'b0100};
        seq_tbl[6] = '{1'b1, 4'b1110, 4'b1000};
        seq_tbl[7] = '{1'b1, 4'b1111, 4'b0001};
        seq_tbl[8] = '{1'b1, 4'b0100, 4'b0100};
        seq_tbl[9] = '{1'b1, 4'b0010, 4'b0010};

        fair_tbl[0] = '{1'b0, 4'b1111, 4'b0000};
        fair_tbl[1] = '{1'b0, 4'b1111, 4'b0000};
        for (int i = 0; i < 8; i++)
            fair_tbl[2+i] = '{1'b1, 4'b1111, 4'(1 << (i % 4))};

        for (int i = 0; i < 10; i++) begin
            cycle($sformatf("seq%0d", i), seq_tbl[i].rst, seq_tbl[i].req, 1'b1, seq_tbl[i].gnt);
            if (i < 2) check($sformatf("reset_ptr%0d", i), 32'(dut.ptr), 32'd0);
        end

        for (int i = 0; i < 10; i++)
            cycle($sformatf("fair%0d", i), fair_tbl[i].rst, fair_tbl[i].req, 1'b1, fair_tbl[i].gnt);

        // Idle: grant 0100 leaves ptr at 3, which must survive empty cycles.
        cycle("idle_rst", 1'b0, 4'b0000, 1'b1, 4'b0000);
        cycle("idle_g2", 1'b1, 4'b0100, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("idle%0d", i), 1'b1, 4'b0000, 1'b1, 4'b0000);
            check($sformatf("idle_ptr%0d", i), 32'(dut.ptr), 32'd3);
        end
        cycle("idle_wake", 1'b1, 4'b1001, 1'b1, 4'b1000);

        // Mid-run reset while all request.
        cycle("mid0", 1'b1, 4'b1111, 1'b0, 4'b0000);
        cycle("mid1", 1'b1, 4'b1111, 1'b0, 4'b0000);
        cycle("mid_rst", 1'b0, 4'b1111, 1'b1, 4'b0000);
        cycle("mid_after", 1'b1, 4'b1111, 1'b1, 4'b0001);

        for (int i = 0; i < 10000; i++)
            cycle("rand", ($urandom_range(0, 63) != 0), 4'($urandom_range(0, 15)), 1'b0, 4'b0000);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
